// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter (reverse double dabble)
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   bcd_input,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      binary_output,
    output logic                  bcd_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                digit_bad;
    logic [WORK_W-1:0]   shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        err_d     = err_q;
        digit_bad = 1'b0;
        shifted   = work_q >> 1;

        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_input[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end

        // Inverse of the add-3 step: a digit that became >= 8 after the shift borrowed 16, not 10
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
                shifted[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (digit_bad) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end else begin
                        state_d = SHIFT;
                        work_d  = {bcd_input, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bin_d   = shifted[BIN_W-1:0];
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign binary_output = bin_q;
    assign bcd_error     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - scoreboard bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] bcd_input = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  binary_output;
    logic        bcd_error;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [10:0] sb[$];
    logic        sweep_done = 1'b0;

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bcd_input(bcd_input),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .binary_output(binary_output),
        .bcd_error(bcd_error),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    // Drive one word; optionally queue the expected {error, value} for the monitor.
    task automatic send(input logic [11:0] word, input logic [10:0] exp, input bit push);
        bit accepted = 1'b0;
        bcd_input = word;
        in_valid  = 1'b1;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(exp);
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                bcd_input = 12'hFFF;
                accepted  = 1'b1;
            end
        end
        if (!accepted) check("accept_timeout", 0, 1);
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is seen high.
    task automatic measure_latency(input string tag, input int exp);
        int k = 1;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, k, exp);
    endtask

    task automatic wait_out_valid();
        int k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                check("result_value", binary_output, e[9:0]);
                check("result_error", bcd_error, e[10]);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_binary", binary_output, 0);
        check("rst_error", bcd_error, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Max value and valid-word latency
        send(12'h999, {1'b0, 10'd999}, 1'b1);
        check("busy_after_accept", busy, 1);
        measure_latency("latency_valid", 11);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back to back with out_ready held high
        send(12'h000, {1'b0, 10'd0}, 1'b1);
        wait_out_valid();
        @(posedge clk); #1;
        check("in_ready_after_hs_0", in_ready, 1);
        send(12'h255, {1'b0, 10'd255}, 1'b1);
        wait_out_valid();
        @(posedge clk); #1;
        check("in_ready_after_hs_255", in_ready, 1);
        send(12'h100, {1'b0, 10'd100}, 1'b1);
        wait_out_valid();
        @(posedge clk); #1;
        check("in_ready_after_hs_100", in_ready, 1);

        // Illegal digits
        out_ready = 1'b0;
        send(12'h12A, {1'b1, 10'd0}, 1'b1);
        measure_latency("latency_invalid", 1);
        check("invalid_error", bcd_error, 1);
        check("invalid_binary", binary_output, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(12'hF00, {1'b1, 10'd0}, 1'b1);
        wait_out_valid();
        @(posedge clk); #1;

        // Backpressure in DONE
        out_ready = 1'b0;
        send(12'h473, {1'b0, 10'd473}, 1'b1);
        wait_out_valid();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_binary", binary_output, 473);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("retain_binary", binary_output, 473);

        // Reset in the middle of SHIFT
        send(12'h512, 11'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_binary", binary_output, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        begin
            bit rose = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (out_valid) rose = 1'b1;
            end
            check("midrst_no_out_valid", rose, 0);
        end

        // Full sweep with random gaps on both sides
        fork
            begin
                for (int v = 0; v < 1000; v++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(to_bcd(v), {1'b0, 10'(v)}, 1'b1);
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
